alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle controller in front of the 3-bit ALU operation decoder. It accepts one opcode at a time over a valid/ready handshake and drives the decoder's `address` with a qualifying one-cycle enable strobe. For the memory opcodes (6 = save, 7 = load) it runs a request/acknowledge exchange with the memory port. It reports completion, optional timeout errors, and a running count of completed operations.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 15: maximum number of `MEM_WAIT` cycles without `mem_ack`. Used only when the timeout feature is compiled in. Legal range 1..255.
- `CNT_W`, default 8: width of `instr_count`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `instr_valid` in 1: requester has an opcode.
- `instr_op` in 3: opcode. 0 suma, 1 complemento, 2 shift_R, 3 shift_l, 4 compC, 5 compn, 6 save, 7 load.
- `instr_ready` out 1: sequencer can accept an opcode.
- `address` out 3: registered opcode to the decoder.
- `op_en` out 1: one-cycle strobe; `address` is valid while it is high.
- `mem_req` out 1: memory request, for opcodes 6 and 7 only.
- `mem_we` out 1: 1 for save (6), 0 for load (7); meaningful only while `mem_req` = 1.
- `mem_ack` in 1: memory completion; sampled only while `mem_req` = 1.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: one-cycle timeout pulse, coincident with `done`.
- `busy` out 1: high in every state except IDLE.
- `instr_count` out CNT_W: number of completed operations; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, ISSUE, MEM_WAIT, DONE. Encoding is free.
- **IDLE**
  - `instr_ready` = 1.
  - When `instr_valid` & `instr_ready`: latch `instr_op` into `address` and go to ISSUE.
- **ISSUE** (exactly one cycle)
  - `op_en` = 1.
  - For opcodes 0–5: go to DONE.
  - For opcodes 6/7:
    - `mem_req` = 1 and `mem_we` = (op == 6) in this same cycle.
    - If `mem_ack` = 1 in this cycle: go to DONE. Otherwise go to MEM_WAIT.
- **MEM_WAIT**
  - `mem_req` stays high and `mem_we` stays stable. `op_en` = 0.
  - `mem_ack` = 1 → DONE.
- **DONE** (exactly one cycle)
  - `done` = 1 and `instr_count` increments.
  - Next state is IDLE.
- `address` holds the last issued opcode until the next acceptance. It never changes outside IDLE acceptance.
- `instr_op` is ignored outside IDLE. `instr_valid` held high across operations is accepted again only once the sequencer is back in IDLE.
- Only one operation is ever in flight; there is no queueing.
- `mem_ack` while `mem_req` = 0 is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `instr_ready` = 1 (it is decoded from IDLE).
  - `address` = 0, `op_en` = 0, `mem_req` = 0, `mem_we` = 0.
  - `done` = 0, `error` = 0, `busy` = 0, `instr_count` = 0, timeout counter = 0.
- All outputs except `instr_ready` and `busy` are registered. Those two decode directly from state, with no combinational path from inputs.
- ALU opcode accepted at edge N:
  - `op_en` high in cycle N..N+1.
  - `done` high in cycle N+1..N+2.
  - `instr_ready` high again from edge N+2.
  - Issue interval is 3 cycles.
- Memory opcode with ack k cycles after ISSUE (k = 0 means ack in the ISSUE cycle): `done` comes 2+k cycles after acceptance.
- If `rst_n` is asserted mid-operation, the sequencer returns to IDLE immediately. `mem_req` drops asynchronously, no `done` is produced and `instr_count` is unchanged.

## Configuration
- Macro `ALU_SEQ_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYCLES`, the next state is DONE, `mem_req` drops and `done` and `error` pulse together.
  - `instr_count` still increments.
  - An ack arriving in the same cycle the limit is hit takes priority: `error` = 0.
- Undefined:
  - MEM_WAIT waits indefinitely.
  - `error` is tied to 0 and no counter logic is instantiated.

## Test plan
- Reset, then `instr_op` = 3 with valid held one cycle → `op_en` for one cycle with `address` = 3, `done` 2 cycles after accept, `instr_count` = 1, `mem_req` never high.
- `instr_op` = 6, `mem_ack` raised 4 cycles after ISSUE → `mem_req` = 1 and `mem_we` = 1 for 5 cycles, `done` 6 cycles after accept.
- `instr_op` = 7 with `mem_ack` = 1 in the ISSUE cycle → `mem_we` = 0, DONE the next cycle, no MEM_WAIT.
- `instr_valid` held high with ops 0, 1, 2 presented back-to-back → each accepted 3 cycles apart. 256 completions with `CNT_W` = 8 → `instr_count` wraps to 0.
- With `ALU_SEQ_TIMEOUT_EN` defined and `TIMEOUT_CYCLES` = 15, `instr_op` = 7 and `mem_ack` never asserted → `done` and `error` pulse together and `mem_req` drops. Repeat with ack on the limit cycle → `error` = 0.
- `rst_n` asserted while in MEM_WAIT → `mem_req`, `busy` and `address` go to 0 immediately, `instr_ready` = 1, no `done`.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - opcode handshake, decoder strobe and memory port bundle for alu_op_sequencer
interface alu_op_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             instr_valid;
  logic [2:0]       instr_op;
  logic             instr_ready;
  logic [2:0]       address;
  logic             op_en;
  logic             mem_req;
  logic             mem_we;
  logic             mem_ack;
  logic             done;
  logic             error;
  logic             busy;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instr_valid, instr_op, mem_ack,
    output instr_ready, address, op_en, mem_req, mem_we, done, error, busy, instr_count
  );

  modport slave (
    output instr_valid, instr_op, mem_ack,
    input  instr_ready, address, op_en, mem_req, mem_we, done, error, busy, instr_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - one-at-a-time opcode sequencer with memory req/ack exchange
// Optional MEM_WAIT timeout compiled in with `define ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, MEM_WAIT, DONE} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic [2:0]       address_q;
  logic             op_en_q, mem_req_q, mem_we_q, done_q, error_q;
  logic [CNT_W-1:0] count_q;
  logic             accept, is_mem, timeout_hit;
  logic [2:0]       op_nxt;
  logic             mem_nxt;

  assign accept  = (state == IDLE) && bus.instr_valid;
  assign is_mem  = (address_q[2:1] == 2'b11);
  assign op_nxt  = accept ? bus.instr_op : address_q;
  assign mem_nxt = (op_nxt[2:1] == 2'b11);

`ifdef ALU_SEQ_TIMEOUT_EN
  logic [7:0] tcnt;

  // An ack on the limit cycle wins, so the timeout only fires without ack.
  assign timeout_hit = (state == MEM_WAIT) && !bus.mem_ack && (tcnt == TO_LIM - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 8'd0;
    end else if (state == ISSUE) begin
      tcnt <= 8'd0;
    end else if (state == MEM_WAIT && !bus.mem_ack) begin
      tcnt <= tcnt + 8'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TO_LIM;
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = ISSUE;
      ISSUE:    state_nxt = (!is_mem || bus.mem_ack) ? DONE : MEM_WAIT;
      MEM_WAIT: if (bus.mem_ack || timeout_hit) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_q <= 3'd0;
      op_en_q   <= 1'b0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      if (accept) begin
        address_q <= bus.instr_op;
      end
      op_en_q   <= (state_nxt == ISSUE);
      mem_req_q <= mem_nxt && (state_nxt == ISSUE || state_nxt == MEM_WAIT);
      mem_we_q  <= mem_nxt && (op_nxt == 3'd6) && (state_nxt == ISSUE || state_nxt == MEM_WAIT);
      done_q    <= (state_nxt == DONE);
      error_q   <= timeout_hit;
      if (state_nxt == DONE) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.busy        = (state != IDLE);
  assign bus.address     = address_q;
  assign bus.op_en       = op_en_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.done        = done_q;
  assign bus.error       = error_q;
  assign bus.instr_count = count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  localparam int T = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_count = 0;
  int   completions = 0;

  alu_op_sequencer_if #(.CNT_W(8)) bus ();

  alu_op_sequencer #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // k = cycle index after ISSUE (0 = ISSUE cycle) at which mem_ack is driven.
  task automatic run_op(input logic [2:0] op, input int k);
    bit mem;
    bit err;
    int d;
    mem = (op >= 3'd6);
    err = 1'b0;
    d   = 0;
    if (mem) begin
      d = k;
`ifdef ALU_SEQ_TIMEOUT_EN
      if (k > T) begin
        d   = T;
        err = 1'b1;
      end
`endif
    end
    check("ready_idle", 32'(bus.instr_ready), 32'(1));
    check("busy_idle", 32'(bus.busy), 32'(0));
    bus.instr_valid = 1'b1;
    bus.instr_op    = op;
    step();
    bus.instr_valid = 1'b0;
    bus.instr_op    = 3'($urandom);
    for (int i = 0; i <= d; i++) begin
      check("op_en", 32'(bus.op_en), 32'(i == 0));
      check("address", 32'(bus.address), 32'(op));
      check("mem_req", 32'(bus.mem_req), 32'(mem));
      if (mem) check("mem_we", 32'(bus.mem_we), 32'(op == 3'd6));
      check("done_early", 32'(bus.done), 32'(0));
      check("busy_op", 32'(bus.busy), 32'(1));
      check("ready_op", 32'(bus.instr_ready), 32'(0));
      bus.mem_ack = mem ? (i == k) : 1'($urandom);
      step();
    end
    bus.mem_ack = 1'b0;
    exp_count   = (exp_count + 1) % 256;
    completions++;
    check("done", 32'(bus.done), 32'(1));
    check("error", 32'(bus.error), 32'(err));
    check("count", 32'(bus.instr_count), 32'(exp_count));
    check("mem_req_done", 32'(bus.mem_req), 32'(0));
    check("op_en_done", 32'(bus.op_en), 32'(0));
    check("address_done", 32'(bus.address), 32'(op));
    check("ready_done", 32'(bus.instr_ready), 32'(0));
    step();
    check("done_clear", 32'(bus.done), 32'(0));
    check("error_clear", 32'(bus.error), 32'(0));
    check("ready_back", 32'(bus.instr_ready), 32'(1));
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op    = 3'd0;
    bus.mem_ack     = 1'b0;
    rst_n           = 1'b0;
    step();
    step();
    check("rst_address", 32'(bus.address), 32'(0));
    check("rst_op_en", 32'(bus.op_en), 32'(0));
    check("rst_mem_req", 32'(bus.mem_req), 32'(0));
    check("rst_mem_we", 32'(bus.mem_we), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_error", 32'(bus.error), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_ready", 32'(bus.instr_ready), 32'(1));
    check("rst_count", 32'(bus.instr_count), 32'(0));
    rst_n = 1'b1;
    step();

    run_op(3'd3, 0);
    run_op(3'd6, 4);
    run_op(3'd7, 0);

    // valid held high across three ops: accepted every third cycle
    bus.instr_valid = 1'b1;
    bus.instr_op    = 3'd0;
    for (int c = 0; c < 9; c++) begin
      step();
      check("b2b_op_en", 32'(bus.op_en), 32'(c % 3 == 0));
      check("b2b_done", 32'(bus.done), 32'(c % 3 == 1));
      if (c % 3 == 0) begin
        check("b2b_address", 32'(bus.address), 32'(c / 3));
        bus.instr_op = 3'(c / 3 + 1);
      end
    end
    bus.instr_valid = 1'b0;
    exp_count   = (exp_count + 3) % 256;
    completions = completions + 3;
    check("b2b_count", 32'(bus.instr_count), 32'(exp_count));
    step();

`ifdef ALU_SEQ_TIMEOUT_EN
    run_op(3'd7, 1000);
    run_op(3'd7, T);
    run_op(3'd6, T + 1);
`endif

    while (completions < 256) begin
      run_op(3'($urandom), int'($urandom_range(0, 20)));
    end
    check("count_wrap", 32'(bus.instr_count), 32'(0));
    for (int n = 0; n < 6; n++) begin
      run_op(3'($urandom), int'($urandom_range(0, 20)));
    end

    // asynchronous reset while waiting on memory
    bus.instr_valid = 1'b1;
    bus.instr_op    = 3'd6;
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    check("pre_rst_mem_req", 32'(bus.mem_req), 32'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(bus.mem_req), 32'(0));
    check("arst_busy", 32'(bus.busy), 32'(0));
    check("arst_address", 32'(bus.address), 32'(0));
    check("arst_ready", 32'(bus.instr_ready), 32'(1));
    check("arst_done", 32'(bus.done), 32'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    exp_count = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("post_rst_done", 32'(bus.done), 32'(0));
      check("post_rst_count", 32'(bus.instr_count), 32'(0));
    end
    run_op(3'd1, 0);
    run_op(3'd7, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
